// File: rtl/inst_rom_pkg.sv
// Shared types and constants for the instruction ROM and its run-time loader.
package inst_rom_pkg;

    typedef enum logic {
        RST_DISABLE = 1'b0,
        RST_ENABLE  = 1'b1
    } reset_status_t;

    typedef enum logic {
        CHIP_DISABLE = 1'b0,
        CHIP_ENABLE  = 1'b1
    } chip_status_t;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_FLUSH = 2'd2
    } rom_load_state_t;

    // Instruction returned whenever a fetch cannot be served (bubble).
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam int ROM_DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/inst_rom_if.sv
// Instruction fetch bus: the PC stage drives ce/addr, the memory answers with data.
interface i_instbus;
    import inst_rom_pkg::*;

    chip_status_t ce;
    logic [31:0]  addr;
    logic [31:0]  data;

    modport master (output ce, output addr, input data);
    modport slave  (input ce, input addr, output data);

endinterface

// File: rtl/inst_rom_loader.sv
// Byte-stream loader: packs little-endian bytes into 32-bit words and emits
// one write per completed word, plus a zero-padded write for a trailing partial word.
module inst_rom_loader
    import inst_rom_pkg::*;
#(
    parameter int DEPTH = ROM_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  reset_status_t              rst,
    input  logic                       load_en,
    input  logic                       load_valid,
    input  logic [7:0]                 load_byte,
    output logic                       load_ready,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     load_words,
    output logic                       load_overflow,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_idx,
    output logic [31:0]                wr_data
);

    localparam int AW = $clog2(DEPTH);

    rom_load_state_t state;
    logic [1:0]      byte_cnt;
    logic [31:0]     word_buf;
    logic            full;

    assign full       = (load_words == (AW+1)'(DEPTH));
    assign load_ready = (state == LD_LOAD) && load_en;
    assign busy       = (state != LD_IDLE);
    assign wr_idx     = load_words[AW-1:0];

    // Memory write request: completed word on the 4th byte, or padded word on flush.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_en   = 1'b0;
        wr_data = word_buf;
        if (rst != RST_ENABLE && !full) begin
            if (load_ready && load_valid && byte_cnt == 2'd3) begin
                wr_en   = 1'b1;
                wr_data = {load_byte, word_buf[23:0]};
            end else if (state == LD_FLUSH) begin
                wr_en   = 1'b1;
            end
        end
    end

    // Loader FSM and byte packer.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (rst == RST_ENABLE) begin
            state         <= LD_IDLE;
            byte_cnt      <= 2'd0;
            word_buf      <= '0;
            load_words    <= '0;
            load_overflow <= 1'b0;
        end else begin
            case (state)
                LD_IDLE: begin
                    if (load_en) begin
                        state         <= LD_LOAD;
                        byte_cnt      <= 2'd0;
                        word_buf      <= '0;
                        load_words    <= '0;
                        load_overflow <= 1'b0;
                    end
                end
                LD_LOAD: begin
                    if (!load_en) begin
                        state <= (byte_cnt != 2'd0) ? LD_FLUSH : LD_IDLE;
                    end else if (load_valid) begin
                        if (full) begin
                            load_overflow <= 1'b1;
                        end else if (byte_cnt == 2'd3) begin
                            load_words <= load_words + (AW+1)'(1);
                            byte_cnt   <= 2'd0;
                            word_buf   <= '0;
                        end else begin
                            word_buf[{byte_cnt, 3'b000} +: 8] <= load_byte;
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                LD_FLUSH: begin
                    if (!full) begin
                        load_words <= load_words + (AW+1)'(1);
                    end
                    byte_cnt <= 2'd0;
                    word_buf <= '0;
                    state    <= LD_IDLE;
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/inst_rom.sv
// Word-addressed instruction memory serving the fetch bus combinationally,
// filled at run time by the byte-stream loader. Fetches return NOP while loading.
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int    DEPTH     = ROM_DEPTH_DEFAULT,
    parameter string INIT_FILE = ""
) (
    input  logic                    clk,
    input  reset_status_t           rst,
    i_instbus.slave                 rom,
    input  logic                    load_en,
    input  logic                    load_valid,
    input  logic [7:0]              load_byte,
    output logic                    load_ready,
    output logic                    load_busy,
    output logic [$clog2(DEPTH):0]  load_words,
    output logic                    load_overflow,
    output logic                    fetch_fault
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [AW-1:0] rd_idx;

    inst_rom_loader #(.DEPTH(DEPTH)) u_loader (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .load_valid    (load_valid),
        .load_byte     (load_byte),
        .load_ready    (load_ready),
        .busy          (load_busy),
        .load_words    (load_words),
        .load_overflow (load_overflow),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_data       (wr_data)
    );

    // Loader writes into the instruction array.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; a reset mid-load must keep already-written words.
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_idx = rom.addr[AW+1:2];

    // Misaligned or out-of-range fetches fault only while the bus is enabled.
    always_comb begin
        fetch_fault = (rom.ce == CHIP_ENABLE) &&
                      ((rom.addr[1:0] != 2'b00) || (|rom.addr[31:AW+2]));
    end

    // Zero-latency read mux; anything unservable becomes a bubble.
    always_comb begin
        rom.data = NOP_INST;
        if (rom.ce == CHIP_ENABLE && !load_busy && !fetch_fault) begin
            rom.data = mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: randomized byte loads against a word-level
// reference image, fetch responses checked by an independent negedge monitor.
module tb_inst_rom;
    import inst_rom_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } fetch_exp_t;

    logic          clk = 1'b0;
    reset_status_t rst;
    logic          load_en;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_ready;
    logic          load_busy;
    logic [AW:0]   load_words;
    logic          load_overflow;
    logic          fetch_fault;

    i_instbus bus ();

    inst_rom #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom           (bus),
        .load_en       (load_en),
        .load_valid    (load_valid),
        .load_byte     (load_byte),
        .load_ready    (load_ready),
        .load_busy     (load_busy),
        .load_words    (load_words),
        .load_overflow (load_overflow),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    // Reference image: word contents plus which words are known.
    logic [31:0] m_mem   [DEPTH];
    bit          m_valid [DEPTH];
    int          m_words;
    bit          m_ovf;

    fetch_exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result of loading a byte stream: bytes grouped four at a time,
    // little-endian, last word zero padded, only the first DEPTH words kept.
    task automatic model_load(input logic [7:0] b[$]);
        int n = b.size();
        m_words = (n + 3) / 4;
        if (m_words > DEPTH) m_words = DEPTH;
        m_ovf = (n > 4 * DEPTH);
        for (int w = 0; w < m_words; w++) begin
            logic [31:0] word = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < n) word[8*k +: 8] = b[4*w+k];
            end
            m_mem[w]   = word;
            m_valid[w] = 1'b1;
        end
    endtask

    task automatic send_bytes(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) begin
            load_valid = 1'b1;
            load_byte  = b[i];
            @(negedge clk);
            check("ready_byte", load_ready, 1);
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic load_prog(input logic [7:0] b[$]);
        int  n = b.size();
        bit  expect_flush;
        load_en = 1'b1;
        tick();
        check("busy_start", load_busy, 1);
        send_bytes(b);
        // Drop enable with a byte still offered: that byte must not be taken.
        load_en    = 1'b0;
        load_valid = 1'b1;
        load_byte  = 8'hFF;
        @(negedge clk);
        check("ready_drop", load_ready, 0);
        tick();
        load_valid = 1'b0;
        model_load(b);
        expect_flush = (n % 4 != 0) && (n < 4 * DEPTH);
        check("flush_busy", load_busy, expect_flush);
        for (int k = 0; k < 4 && load_busy; k++) tick();
        check("idle_after_load", load_busy, 0);
        check("load_words", load_words, m_words);
        check("load_overflow", load_overflow, m_ovf);
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] ed, input logic ef);
        fetch_exp_t e;
        e.data  = ed;
        e.fault = ef;
        bus.ce   = CHIP_ENABLE;
        bus.addr = a;
        exp_q.push_back(e);
        tick();
        bus.ce = CHIP_DISABLE;
    endtask

    // Fetch with expectation taken from the reference image; unknown words skipped.
    task automatic model_fetch(input logic [31:0] a);
        logic flt = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
        if (flt) do_fetch(a, 32'h0, 1'b1);
        else if (m_valid[a[AW+1:2]]) do_fetch(a, m_mem[a[AW+1:2]], 1'b0);
    endtask

    // Monitor: every enabled fetch cycle is one response to score.
    always @(negedge clk) begin
        if (bus.ce == CHIP_ENABLE) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: addr %h data %h with no expectation", bus.addr, bus.data);
            end else begin
                fetch_exp_t e;
                e = exp_q.pop_front();
                check("fetch_data", bus.data, e.data);
                check("fetch_fault", fetch_fault, e.fault);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] p[$];
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        rst        = RST_ENABLE;
        load_en    = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        bus.ce     = CHIP_DISABLE;
        bus.addr   = 32'h0;
        tick();
        tick();
        rst = RST_DISABLE;
        check("rst_busy", load_busy, 0);
        check("rst_words", load_words, 0);
        check("rst_overflow", load_overflow, 0);
        check("rst_ready", load_ready, 0);
        check("rst_fault", fetch_fault, 0);

        // Two full words.
        p = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load_prog(p);
        do_fetch(32'h4, 32'hDEADBEEF, 1'b0);
        do_fetch(32'h0, 32'h12345678, 1'b0);

        // Partial word padded by the flush cycle.
        p = '{8'hAA, 8'hBB};
        load_prog(p);
        do_fetch(32'h0, 32'h0000BBAA, 1'b0);

        // Fetch during a load returns a bubble; memory survives an empty load.
        load_en = 1'b1;
        tick();
        do_fetch(32'h0, 32'h0, 1'b0);
        load_en = 1'b0;
        tick();
        m_words = 0;
        m_ovf   = 1'b0;
        check("empty_load_busy", load_busy, 0);
        check("empty_load_words", load_words, 0);
        do_fetch(32'h0, 32'h0000BBAA, 1'b0);

        // Overflow: 20 bytes into 4 words, ready stays high throughout.
        p = {};
        for (int i = 0; i < 20; i++) p.push_back(8'(8'h10 + i));
        load_prog(p);
        do_fetch(32'hC, 32'h1F1E1D1C, 1'b0);
        model_fetch(32'h8);

        // Disabled bus and faulting addresses.
        bus.addr = 32'h2;
        #1;
        check("ce_off_data", bus.data, 32'h0);
        check("ce_off_fault", fetch_fault, 0);
        do_fetch(32'h2, 32'h0, 1'b1);
        do_fetch(32'h10, 32'h0, 1'b1);
        do_fetch(32'h8000_0004, 32'h0, 1'b1);

        // Reset after word 0 and three bytes of word 1.
        p = '{8'h01, 8'h23, 8'h45, 8'h67};
        load_en = 1'b1;
        tick();
        send_bytes(p);
        p = '{8'h89, 8'hAB, 8'hCD};
        send_bytes(p);
        m_mem[0]   = 32'h67452301;
        m_valid[0] = 1'b1;
        rst     = RST_ENABLE;
        load_en = 1'b0;
        tick();
        rst     = RST_DISABLE;
        m_words = 0;
        m_ovf   = 1'b0;
        check("rst_mid_busy", load_busy, 0);
        check("rst_mid_words", load_words, m_words);
        check("rst_mid_overflow", load_overflow, m_ovf);
        do_fetch(32'h0, 32'h67452301, 1'b0);
        model_fetch(32'h4);

        // Randomized loads and fetches against the reference image.
        for (int it = 0; it < 25; it++) begin
            int n = $urandom_range(0, 22);
            p = {};
            for (int i = 0; i < n; i++) p.push_back(8'($urandom));
            load_prog(p);
            for (int w = 0; w < DEPTH; w++) model_fetch(32'(4 * w));
            for (int k = 0; k < 3; k++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 20));
                model_fetch(a);
            end
        end

        tick();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
